// File: rtl/ex_stage_pkg.sv
// Shared encodings and bundle layouts for the execute stage.
// Packed structs are listed MSB first, so member order fixes the bit offsets.
package ex_stage_pkg;

  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b011000,
    ALU_OR  = 6'b011110,
    ALU_XOR = 6'b010110,
    ALU_NOR = 6'b010001,
    ALU_A   = 6'b011010,
    ALU_SLL = 6'b100000,
    ALU_SRL = 6'b100001,
    ALU_SRA = 6'b100011,
    ALU_EQ  = 6'b110011,
    ALU_NEQ = 6'b110001,
    ALU_LT  = 6'b110101,
    ALU_LEZ = 6'b111101,
    ALU_LTZ = 6'b111011,
    ALU_GTZ = 6'b111111
  } alu_fun_e;

  typedef enum logic [1:0] {
    REGDST_RD = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RA = 2'b10,
    REGDST_XP = 2'b11
  } reg_dst_e;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_PC   = 2'b10,
    MTR_RSVD = 2'b11
  } mem_to_reg_e;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_XP = 5'd26;

  // ID_EX: 230 bits
  typedef struct packed {
    reg_dst_e    reg_dst;    // [229:228]
    logic        branch;     // [227]
    logic [31:0] imm32;      // [226:195]
    logic [4:0]  shamt;      // [194:190]
    logic [31:0] pc_plus4;   // [189:158]
    logic        lu_op;      // [157]
    logic [31:0] lu_data;    // [156:125]
    mem_to_reg_e mem_to_reg; // [124:123]
    logic        reg_write;  // [122]
    logic        mem_read;   // [121]
    logic        mem_write;  // [120]
    logic [31:0] target;     // [119:88]
    logic        alu_src1;   // [87]
    logic        alu_src2;   // [86]
    logic [5:0]  alu_fun;    // [85:80]
    logic        sign;       // [79]
    logic [4:0]  rd;         // [78:74]
    logic [4:0]  rt;         // [73:69]
    logic [4:0]  rs;         // [68:64]
    logic [31:0] rt_data;    // [63:32]
    logic [31:0] rs_data;    // [31:0]
  } id_ex_t;

  // EX_MEM: 106 bits
  typedef struct packed {
    logic [31:0] pc_plus4;   // [105:74]
    mem_to_reg_e mem_to_reg; // [73:72]
    logic        reg_write;  // [71]
    logic        mem_read;   // [70]
    logic        mem_write;  // [69]
    logic [4:0]  write_reg;  // [68:64]
    logic [31:0] store_data; // [63:32]
    logic [31:0] result;     // [31:0]
  } ex_mem_t;

endpackage

// File: rtl/ex_stage_forwarding_unit.sv
// Operand bypass for the execute stage: EX_MEM beats MEM_WB, register $0 never forwards.
module forwarding_unit (
  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] ex_mem_data,
  input  logic        mem_wb_reg_write,
  input  logic [4:0]  mem_wb_write_reg,
  input  logic [31:0] mem_wb_data,
  input  logic [4:0]  rs,
  input  logic [31:0] rs_data,
  input  logic [4:0]  rt,
  input  logic [31:0] rt_data,
  output logic [31:0] fwd_rs,
  output logic [31:0] fwd_rt
);

  // A load in EX_MEM has no data yet; the load-use stall in decode covers it.
  function automatic logic [31:0] select(input logic [4:0] src, input logic [31:0] dflt);
    if (ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd == src && src != 5'd0)
      return ex_mem_data;
    else if (mem_wb_reg_write && mem_wb_write_reg == src && src != 5'd0)
      return mem_wb_data;
    else
      return dflt;
  endfunction

  assign fwd_rs = select(rs, rs_data);
  assign fwd_rt = select(rt, rt_data);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/shift/compare, branch resolution,
// and the EX_MEM pipeline register.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int EX_MEM_W = 106,
  parameter int ID_EX_W  = 230
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_EX_W-1:0]  ID_EX,
  input  logic                MEM_WB_RegWrite,
  input  logic [4:0]          MEM_WB_WriteReg,
  input  logic [31:0]         MEM_WB_RegWriteData,
  output logic [4:0]          ID_EX_Rt,
  output logic                ID_EX_MemRead,
  output logic [4:0]          EX_MEM_Rd,
  output logic [31:0]         EX_MEM_RdData,
  output logic                EX_MEM_RegWrite,
  output logic                PCSrcB,
  output logic [31:0]         branch_address,
  output logic                ID_Flush,
  output logic [EX_MEM_W-1:0] EX_MEM
);

  id_ex_t      id;
  ex_mem_t     ex_mem_q;
  ex_mem_t     ex_mem_d;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;

  assign id = id_ex_t'(ID_EX);

  forwarding_unit u_fwd (
    .ex_mem_reg_write (ex_mem_q.reg_write),
    .ex_mem_mem_read  (ex_mem_q.mem_read),
    .ex_mem_rd        (ex_mem_q.write_reg),
    .ex_mem_data      (EX_MEM_RdData),
    .mem_wb_reg_write (MEM_WB_RegWrite),
    .mem_wb_write_reg (MEM_WB_WriteReg),
    .mem_wb_data      (MEM_WB_RegWriteData),
    .rs               (id.rs),
    .rs_data          (id.rs_data),
    .rt               (id.rt),
    .rt_data          (id.rt_data),
    .fwd_rs           (fwd_rs),
    .fwd_rt           (fwd_rt)
  );

  assign op_a = id.alu_src1 ? {27'b0, id.shamt} : fwd_rs;
  assign op_b = id.alu_src2 ? id.imm32 : fwd_rt;

  always_comb begin
    alu_res = '0;
    case (id.alu_fun)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_A:   alu_res = op_a;
      ALU_SLL: alu_res = op_b << op_a[4:0];
      ALU_SRL: alu_res = op_b >> op_a[4:0];
      ALU_SRA: alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
      ALU_EQ:  alu_res = {31'b0, op_a == op_b};
      ALU_NEQ: alu_res = {31'b0, op_a != op_b};
      ALU_LT:  alu_res = {31'b0, id.sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b)};
      ALU_LEZ: alu_res = {31'b0, op_a[31] | (op_a == '0)};
      ALU_LTZ: alu_res = {31'b0, op_a[31]};
      ALU_GTZ: alu_res = {31'b0, ~op_a[31] & (op_a != '0)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.result     = id.lu_op ? id.lu_data : alu_res;
    ex_mem_d.store_data = fwd_rt;
    ex_mem_d.mem_write  = id.mem_write;
    ex_mem_d.mem_read   = id.mem_read;
    ex_mem_d.reg_write  = id.reg_write;
    ex_mem_d.mem_to_reg = id.mem_to_reg;
    ex_mem_d.pc_plus4   = id.pc_plus4;
    case (id.reg_dst)
      REGDST_RD: ex_mem_d.write_reg = id.rd;
      REGDST_RT: ex_mem_d.write_reg = id.rt;
      REGDST_RA: ex_mem_d.write_reg = REG_RA;
      REGDST_XP: ex_mem_d.write_reg = REG_XP;
      default:   ex_mem_d.write_reg = id.rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign EX_MEM          = ex_mem_q;
  assign EX_MEM_Rd       = ex_mem_q.write_reg;
  assign EX_MEM_RegWrite = ex_mem_q.reg_write;
  // jal/jalr carry the link address, not the ALU result, as their writeback value.
  assign EX_MEM_RdData   = (ex_mem_q.mem_to_reg == MTR_PC) ? ex_mem_q.pc_plus4 : ex_mem_q.result;
  assign ID_EX_Rt        = id.rt;
  assign ID_EX_MemRead   = id.mem_read;
  assign PCSrcB          = id.branch & alu_res[0];
  assign ID_Flush        = PCSrcB;
  assign branch_address  = id.target;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios followed by randomized
// instructions checked against a behavioural model of the execute stage.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [229:0] ID_EX;
  logic         MEM_WB_RegWrite;
  logic [4:0]   MEM_WB_WriteReg;
  logic [31:0]  MEM_WB_RegWriteData;
  logic [4:0]   ID_EX_Rt;
  logic         ID_EX_MemRead;
  logic [4:0]   EX_MEM_Rd;
  logic [31:0]  EX_MEM_RdData;
  logic         EX_MEM_RegWrite;
  logic         PCSrcB;
  logic [31:0]  branch_address;
  logic         ID_Flush;
  logic [105:0] EX_MEM;

  ex_stage #(.EX_MEM_W(106), .ID_EX_W(230)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ID_EX               (ID_EX),
    .MEM_WB_RegWrite     (MEM_WB_RegWrite),
    .MEM_WB_WriteReg     (MEM_WB_WriteReg),
    .MEM_WB_RegWriteData (MEM_WB_RegWriteData),
    .ID_EX_Rt            (ID_EX_Rt),
    .ID_EX_MemRead       (ID_EX_MemRead),
    .EX_MEM_Rd           (EX_MEM_Rd),
    .EX_MEM_RdData       (EX_MEM_RdData),
    .EX_MEM_RegWrite     (EX_MEM_RegWrite),
    .PCSrcB              (PCSrcB),
    .branch_address      (branch_address),
    .ID_Flush            (ID_Flush),
    .EX_MEM              (EX_MEM)
  );

  always #5 clk = ~clk;

  // Instruction fields being issued
  logic [31:0] rs_data, rt_data, target, lu_data, pc4, imm;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  alu_fun;
  logic        src1, src2, sgn, mem_read, mem_write, reg_write, lu_op, branch;
  logic [1:0]  mtr, regdst;

  // Expected contents of the EX_MEM register
  logic [31:0] m_result = '0, m_store = '0, m_pc4 = '0;
  logic [4:0]  m_wreg = '0;
  logic        m_we = 1'b0, m_mr = 1'b0, m_mw = 1'b0;
  logic [1:0]  m_mtr = '0;
  logic [31:0] e_alu, e_rt;

  int n_cmp = 0;
  int n_fail = 0;

  logic [5:0] codes [16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110,
                             6'b010001, 6'b011010, 6'b100000, 6'b100001, 6'b100011,
                             6'b110011, 6'b110001, 6'b110101, 6'b111101, 6'b111011,
                             6'b111111};

  task automatic check(input string tag, input logic [105:0] obs, input logic [105:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_fields();
    rs_data = '0; rt_data = '0; target = '0; lu_data = '0; pc4 = '0; imm = '0;
    rs = '0; rt = '0; rd = '0; shamt = '0; alu_fun = '0;
    src1 = 0; src2 = 0; sgn = 0; mem_read = 0; mem_write = 0; reg_write = 0;
    lu_op = 0; branch = 0; mtr = '0; regdst = '0;
    MEM_WB_RegWrite = 0; MEM_WB_WriteReg = '0; MEM_WB_RegWriteData = '0;
  endtask

  function automatic logic [31:0] m_writeback();
    return (m_mtr == 2'b10) ? m_pc4 : m_result;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] stale);
    if (r == 5'd0) return stale;
    if (m_we && !m_mr && m_wreg == r) return m_writeback();
    if (MEM_WB_RegWrite && MEM_WB_WriteReg == r) return MEM_WB_RegWriteData;
    return stale;
  endfunction

  function automatic logic [31:0] m_alu(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic s);
    int unsigned sh;
    logic [63:0] wide;
    logic [31:0] pow;
    sh = a % 32;
    pow = 32'd1 << sh;
    case (f)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b011000: return a & b;
      6'b011110: return a | b;
      6'b010110: return a ^ b;
      6'b010001: return ~(a | b);
      6'b011010: return a;
      6'b100000: begin wide = 64'(b) * 64'(pow); return wide[31:0]; end
      6'b100001: return b / pow;
      6'b100011: return b[31] ? ~((~b) / pow) : b / pow;
      6'b110011: return 32'(a == b);
      6'b110001: return 32'(a != b);
      6'b110101: return s ? 32'(int'(a) < int'(b)) : 32'(a < b);
      6'b111101: return 32'(int'(a) <= 0);
      6'b111011: return 32'(int'(a) < 0);
      6'b111111: return 32'(int'(a) > 0);
      default:   return 32'd0;
    endcase
  endfunction

  // Drive the instruction and check everything visible before the clock edge.
  task automatic apply();
    logic [31:0] a, b;
    logic        taken;
    ID_EX = {regdst, branch, imm, shamt, pc4, lu_op, lu_data, mtr, reg_write, mem_read,
             mem_write, target, src1, src2, alu_fun, sgn, rd, rt, rs, rt_data, rs_data};
    #2;
    e_rt  = m_fwd(rt, rt_data);
    a     = src1 ? {27'b0, shamt} : m_fwd(rs, rs_data);
    b     = src2 ? imm : e_rt;
    e_alu = m_alu(alu_fun, a, b, sgn);
    taken = branch && e_alu[0];
    check("pcsrcb", PCSrcB, taken);
    check("id_flush", ID_Flush, taken);
    check("branch_address", branch_address, target);
    check("id_ex_rt", ID_EX_Rt, rt);
    check("id_ex_memread", ID_EX_MemRead, mem_read);
    check("ex_mem_rd", EX_MEM_Rd, m_wreg);
    check("ex_mem_regwrite", EX_MEM_RegWrite, m_we);
    check("ex_mem_rddata", EX_MEM_RdData, m_writeback());
  endtask

  task automatic clock();
    @(posedge clk);
    #1;
    if (reset) begin
      m_result = '0; m_store = '0; m_pc4 = '0; m_wreg = '0;
      m_we = 0; m_mr = 0; m_mw = 0; m_mtr = '0;
    end else begin
      m_result = lu_op ? lu_data : e_alu;
      m_store  = e_rt;
      m_pc4    = pc4;
      m_mtr    = mtr;
      m_we     = reg_write;
      m_mr     = mem_read;
      m_mw     = mem_write;
      case (regdst)
        2'b00:   m_wreg = rd;
        2'b01:   m_wreg = rt;
        2'b10:   m_wreg = 5'd31;
        default: m_wreg = 5'd26;
      endcase
    end
    check("ex_mem", EX_MEM, {m_pc4, m_mtr, m_we, m_mr, m_mw, m_wreg, m_store, m_result});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    clear_fields();
    ID_EX = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_ex_mem", EX_MEM, 106'd0);
    check("reset_pcsrcb", PCSrcB, 1'b0);
    check("reset_rddata", EX_MEM_RdData, 32'd0);
    check("reset_branch_addr", branch_address, 32'd0);
    reset = 1'b0;

    // Fill EX_MEM with a mostly-ones bundle, then reset with a live instruction
    clear_fields();
    rs_data = '1; alu_fun = 6'b011010; pc4 = '1; mtr = 2'b11; regdst = 2'b11;
    reg_write = 1; mem_read = 1; mem_write = 1; rt_data = '1; target = 32'h1234_5678;
    apply(); clock();
    reset = 1'b1;
    apply(); clock();
    check("reset_midop", EX_MEM, 106'd0);
    reset = 1'b0;
    apply(); clock();
    check("after_reset_result", EX_MEM[31:0], 32'hFFFF_FFFF);

    // add $3,$1,$2
    clear_fields();
    rs = 1; rt = 2; rd = 3; rs_data = 5; rt_data = 7; reg_write = 1;
    apply(); clock();
    check("add_result", EX_MEM[31:0], 32'd12);
    check("add_wreg", EX_MEM[68:64], 5'd3);
    check("add_regwrite", EX_MEM[71], 1'b1);

    // Double hazard on $1: EX_MEM writes 100, MEM_WB writes 50
    clear_fields();
    rt = 1; regdst = 2'b01; src2 = 1; imm = 100; reg_write = 1;
    apply(); clock();
    clear_fields();
    rs = 1; rt = 2; rd = 3; rs_data = 5; rt_data = 7; reg_write = 1;
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = 1; MEM_WB_RegWriteData = 50;
    apply(); clock();
    check("hazard_ex_mem_wins", EX_MEM[31:0], 32'd107);
    clear_fields();
    rt = 1; regdst = 2'b01; src2 = 1; imm = 32'h40; reg_write = 1; mem_read = 1; mtr = 2'b01;
    apply(); clock();
    clear_fields();
    rs = 1; rt = 2; rd = 3; rs_data = 5; rt_data = 7; reg_write = 1;
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = 1; MEM_WB_RegWriteData = 50;
    apply(); clock();
    check("hazard_load_skipped", EX_MEM[31:0], 32'd57);

    // beq with both operands forwarded to 9
    clear_fields();
    rt = 4; regdst = 2'b01; src2 = 1; imm = 9; reg_write = 1;
    apply(); clock();
    clear_fields();
    rs = 4; rt = 5; alu_fun = 6'b110011; branch = 1; target = 32'h0040_0040;
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = 5; MEM_WB_RegWriteData = 9;
    apply();
    check("beq_taken", PCSrcB, 1'b1);
    check("beq_flush", ID_Flush, 1'b1);
    check("beq_target", branch_address, 32'h0040_0040);
    clock();
    check("beq_no_write", EX_MEM[71], 1'b0);
    clear_fields();
    rs = 4; rt = 5; rs_data = 9; rt_data = 8; alu_fun = 6'b110011; branch = 1;
    target = 32'h0040_0040;
    apply();
    check("beq_not_taken", PCSrcB, 1'b0);
    check("beq_no_flush", ID_Flush, 1'b0);
    clock();

    // jal then a dependent jr
    clear_fields();
    regdst = 2'b10; mtr = 2'b10; reg_write = 1; pc4 = 32'h0040_0008;
    apply(); clock();
    check("jal_wreg", EX_MEM[68:64], 5'd31);
    check("jal_link", EX_MEM_RdData, 32'h0040_0008);
    clear_fields();
    rs = 31; alu_fun = 6'b011010;
    apply(); clock();
    check("jr_forward", EX_MEM[31:0], 32'h0040_0008);

    // sra, then the same op targeting $0 must not forward
    clear_fields();
    src1 = 1; shamt = 4; rt = 2; rt_data = 32'h8000_0000; alu_fun = 6'b100011;
    rd = 5; reg_write = 1;
    apply(); clock();
    check("sra_result", EX_MEM[31:0], 32'hF800_0000);
    rd = 0;
    apply(); clock();
    clear_fields();
    rs = 0; rs_data = 32'h123; alu_fun = 6'b011010;
    MEM_WB_RegWrite = 1; MEM_WB_WriteReg = 0; MEM_WB_RegWriteData = 32'hDEAD;
    apply(); clock();
    check("zero_reg_no_fwd", EX_MEM[31:0], 32'h123);

    // Undefined ALU code, and store data is rt not the immediate
    clear_fields();
    rs_data = 32'h55; rt_data = 32'h66; src2 = 1; imm = 32'h77; alu_fun = 6'b111110;
    mem_write = 1;
    apply(); clock();
    check("undef_code", EX_MEM[31:0], 32'd0);
    check("store_data_rt", EX_MEM[63:32], 32'h66);

    // Randomized instructions with small register numbers to provoke hazards
    for (int i = 0; i < 300; i++) begin
      clear_fields();
      rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      rs_data = $urandom(); rt_data = $urandom();
      if ($urandom_range(0, 3) == 0) rt_data = rs_data;
      src1 = 1'($urandom()); src2 = 1'($urandom()); sgn = 1'($urandom());
      shamt = 5'($urandom()); imm = $urandom();
      alu_fun = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : codes[$urandom_range(0, 15)];
      mem_read = 1'($urandom()); mem_write = 1'($urandom()); reg_write = 1'($urandom());
      mtr = 2'($urandom()); regdst = 2'($urandom());
      branch = 1'($urandom());
      lu_op = branch ? 1'b0 : ($urandom_range(0, 5) == 0);
      lu_data = $urandom(); pc4 = $urandom(); target = $urandom();
      MEM_WB_RegWrite = 1'($urandom()); MEM_WB_WriteReg = 5'($urandom_range(0, 3));
      MEM_WB_RegWriteData = $urandom();
      reset = ($urandom_range(0, 39) == 0);
      apply(); clock();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline; consumer of the 230-bit ID_EX bundle produced by the decode stage.
- Forwards operands from EX_MEM and MEM_WB and computes the ALU/shift/compare result.
- Resolves conditional branches and raises ID_Flush to squash the younger instruction.
- Registers the result into the EX_MEM bundle.
- Drives back the hazard and forwarding signals the decode stage consumes.

Parameters:
EX_MEM_W, 106, width of EX_MEM bundle
ID_EX_W, 230, width of ID_EX bundle (fixed layout, not tunable)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
ID_EX  input  230  decode bundle: [31:0] RsData, [63:32] RtData, [68:64] Rs, [73:69] Rt, [78:74] Rd, [87] ALUSrc1, [86] ALUSrc2, [85:80] ALUFun, [79] Sign, [119:88] branch target, [121] MemRead, [120] MemWrite, [124:123] MemToReg, [122] RegWrite, [157] LUOp, [156:125] LUData, [189:158] PC_Plus4, [194:190] Shamt, [226:195] Imm32, [227] Branch, [229:228] RegDst
MEM_WB_RegWrite  input  1  writeback enable in WB
MEM_WB_WriteReg  input  5  writeback register
MEM_WB_RegWriteData  input  32  writeback data
ID_EX_Rt  output  5  ID_EX[73:69], for load-use detection
ID_EX_MemRead  output  1  ID_EX[121]
EX_MEM_Rd  output  5  EX_MEM[68:64]
EX_MEM_RdData  output  32  forwardable EX_MEM value
EX_MEM_RegWrite  output  1  EX_MEM[71]
PCSrcB  output  1  branch taken, IF selects branch_address
branch_address  output  32  ID_EX[119:88]
ID_Flush  output  1  equals PCSrcB; decode inserts a bubble
EX_MEM  output  106  [31:0] result, [63:32] store data, [68:64] WriteReg, [69] MemWrite, [70] MemRead, [71] RegWrite, [73:72] MemToReg, [105:74] PC_Plus4

Behaviour:
- Reset: on posedge clk with reset=1, EX_MEM <= 0. Applies even mid-instruction and overrides every other event.
- With ID_EX also zero after reset, all combinational outputs are 0.
- Forwarding for Rs (Rt identical), first match wins:
  1. EX_MEM_RegWrite && ~EX_MEM[70] && EX_MEM_Rd==Rs && Rs!=0 -> EX_MEM_RdData.
  2. MEM_WB_RegWrite && MEM_WB_WriteReg==Rs && Rs!=0 -> MEM_WB_RegWriteData.
  3. Otherwise -> ID_EX field.
  EX_MEM has priority over MEM_WB.
- Operand A = ALUSrc1 ? {27'b0,Shamt} : fwdRs.
- Operand B = ALUSrc2 ? Imm32 : fwdRt.
- ALUFun encodings:
  - ADD 000000, SUB 000001: 32-bit wrap, no overflow trap.
  - AND 011000, OR 011110, XOR 010110, NOR 010001, A 011010.
  - SLL 100000, SRL 100001, SRA 100011: B shifted by A[4:0].
  - Compares give {31'b0,bit}: EQ 110011, NEQ 110001; LT 110101 is signed when Sign=1, else unsigned; LEZ 111101, LTZ 111011, GTZ 111111 test A as signed.
  - Undefined code -> result 0.
- Result written to EX_MEM[31:0] = LUOp ? LUData : ALU result.
- Store data EX_MEM[63:32] = fwdRt, never Imm32.
- WriteReg from RegDst: 00 Rd, 01 Rt, 10 5'd31, 11 5'd26.
- PCSrcB = Branch && result[0]. Purely combinational from ID_EX and forwarding sources, valid in the same cycle.
  - The branch itself still enters EX_MEM; its RegWrite/MemWrite are already 0.
- EX_MEM_RdData = (EX_MEM[73:72]==2'b10) ? EX_MEM[105:74] : EX_MEM[31:0], so jal/jalr forward the link value.
- Latency: one cycle ID_EX -> EX_MEM. No internal stall; a bubble from decode arrives as an all-zero ID_EX and propagates as all-zero EX_MEM.
- A zero RegWrite or WriteReg=0 never forwards.

Decomposition:
- Shared package: ALUFun constants, RegDst/MemToReg encodings, ID_EX and EX_MEM field bit offsets.
- Sub-module forwarding_unit: pure combinational 2-level priority mux per operand.
- ALU logic stays inline.

Test Plan:
- Reset mid-op: EX_MEM=0x...FFFF state, nonzero ID_EX, reset=1 one edge -> EX_MEM==0 next cycle. Deassert -> normal capture on the following edge.
- add $3,$1,$2 with RsData=5, RtData=7, no hazards -> EX_MEM[31:0]=12, WriteReg=3, RegWrite=1.
- Double hazard: EX_MEM writes $1=100 and MEM_WB writes $1=50, stale RsData=5, RtData=7 -> result 107 (EX_MEM wins). With EX_MEM being a load -> 57.
- beq, fwd Rs=Rt=9, Branch=1, ALUFun EQ, target 0x00400040 -> PCSrcB=1, ID_Flush=1, branch_address=0x00400040. With Rt=8 -> both 0.
- jal: RegDst=10, MemToReg=10, RegWrite=1, PC_Plus4=0x00400008 -> WriteReg=31. Next cycle EX_MEM_RdData=0x00400008, and a dependent jr forwards it.
- sra: ALUSrc1=1, Shamt=4, Rt=0x80000000 -> 0xF8000000. Same op writing $0 -> consumer of $0 receives the ID_EX value, not the forwarded one.
